// File: rtl/draw_board_pkg.sv
// draw_board_pkg: VGA stream widths and default board colours shared by the board drawer.
package draw_board_pkg;
  localparam int CNT_W = 11;
  localparam int RGB_W = 12;
  localparam logic [RGB_W-1:0] C_P0  = 12'hF00;
  localparam logic [RGB_W-1:0] C_P1  = 12'h00F;
  localparam logic [RGB_W-1:0] C_CUR = 12'hFF0;
  localparam logic [RGB_W-1:0] C_WIN = 12'hFFF;
endpackage

// File: rtl/draw_board_grid_locator.sv
// grid_locator: single-axis cell locator; tracks cell position, offset inside cell+gap pitch and in-grid flag.
module grid_locator import draw_board_pkg::*; #(
  parameter int ORIGIN = 320,
  parameter int CELL   = 120,
  parameter int GAP    = 8,
  parameter int N      = 3,
  parameter int OW     = $clog2(CELL + GAP),
  parameter int PW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [CNT_W-1:0] count_i,
  output logic [PW-1:0]    pos_o,
  output logic [OW-1:0]    off_o,
  output logic             in_o
);
  logic [PW-1:0] pos_q;
  logic [OW-1:0] off_q;
  logic          in_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      off_q <= '0;
      in_q  <= 1'b0;
    end else if (en_i) begin
      if (count_i == CNT_W'(ORIGIN)) begin
        pos_q <= '0;
        off_q <= '0;
        in_q  <= 1'b1;
      end else if (in_q) begin
        if (off_q == OW'(CELL + GAP - 1)) begin
          off_q <= '0;
          pos_q <= pos_q + 1'b1;
          in_q  <= pos_q != PW'(N - 1);
        end else begin
          off_q <= off_q + 1'b1;
        end
      end else begin
        pos_q <= '0;
        off_q <= '0;
        in_q  <= 1'b0;
      end
    end
  end
  assign pos_o = pos_q;
  assign off_o = off_q;
  assign in_o  = in_q;
endmodule

// File: rtl/draw_board.sv
// draw_board: 2-cycle pipeline drawing a GRID_N x GRID_N board with cursor outline and blinking win line.
module draw_board import draw_board_pkg::*; #(
  parameter int               GRID_N       = 3,
  parameter int               CELL_W       = 120,
  parameter int               CELL_H       = 120,
  parameter int               GAP          = 8,
  parameter int               ORIGIN_X     = 320,
  parameter int               ORIGIN_Y     = 200,
  parameter int               BORDER       = 4,
  parameter int               BLINK_FRAMES = 30,
  parameter logic [RGB_W-1:0] COLOR_P0     = C_P0,
  parameter logic [RGB_W-1:0] COLOR_P1     = C_P1,
  parameter logic [RGB_W-1:0] COLOR_CUR    = C_CUR,
  parameter logic [RGB_W-1:0] COLOR_WIN    = C_WIN
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic [CNT_W-1:0]         hcount_in,
  input  logic [CNT_W-1:0]         vcount_in,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     hblnk_in,
  input  logic                     vblnk_in,
  input  logic [RGB_W-1:0]         rgb_in,
  input  logic                     start_en,
  input  logic                     choice_en,
  input  logic [GRID_N*GRID_N-1:0] cell_occ,
  input  logic [GRID_N*GRID_N-1:0] cell_own,
  input  logic [GRID_N*GRID_N-1:0] win_mask,
  input  logic                     cursor_en,
  input  logic [7:0]               cursor_idx,
  output logic [CNT_W-1:0]         hcount_out,
  output logic [CNT_W-1:0]         vcount_out,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     hblnk_out,
  output logic                     vblnk_out,
  output logic [RGB_W-1:0]         rgb_out
);
  localparam int NC = GRID_N * GRID_N;
  localparam int XW = $clog2(CELL_W + GAP);
  localparam int YW = $clog2(CELL_H + GAP);
  localparam int PW = (GRID_N > 1) ? $clog2(GRID_N) : 1;
  logic [PW-1:0] col, row;
  logic [XW-1:0] xoff;
  logic [YW-1:0] yoff;
  logic in_x, in_y;
  grid_locator #(.ORIGIN(ORIGIN_X), .CELL(CELL_W), .GAP(GAP), .N(GRID_N), .OW(XW), .PW(PW)) u_x (
    .clk(pclk), .rst(rst), .en_i(1'b1), .count_i(hcount_in), .pos_o(col), .off_o(xoff), .in_o(in_x)
  );
  grid_locator #(.ORIGIN(ORIGIN_Y), .CELL(CELL_H), .GAP(GAP), .N(GRID_N), .OW(YW), .PW(PW)) u_y (
    .clk(pclk), .rst(rst), .en_i(hcount_in == '0), .count_i(vcount_in), .pos_o(row), .off_o(yoff), .in_o(in_y)
  );
  // board state captured once per frame so an update never tears mid-frame
  logic            vblnk_prev_q, cur_en_q, phase_q;
  logic [NC-1:0]   occ_q, own_q, win_q;
  logic [7:0]      cur_idx_q, blink_q;
  logic            vrise;
  assign vrise = vblnk_in & ~vblnk_prev_q;
  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      cur_en_q     <= 1'b0;
      cur_idx_q    <= '0;
      occ_q        <= '0;
      own_q        <= '0;
      win_q        <= '0;
      blink_q      <= '0;
      phase_q      <= 1'b0;
    end else begin
      vblnk_prev_q <= vblnk_in;
      if (vrise) begin
        occ_q     <= cell_occ;
        own_q     <= cell_own;
        win_q     <= win_mask;
        cur_en_q  <= cursor_en;
        cur_idx_q <= cursor_idx;
      end
      if (win_q == '0) begin
        blink_q <= '0;
        phase_q <= 1'b0;
      end else if (vrise) begin
        blink_q <= (blink_q == 8'(BLINK_FRAMES - 1)) ? 8'd0 : blink_q + 8'd1;
        phase_q <= phase_q ^ (blink_q == 8'(BLINK_FRAMES - 1));
      end
    end
  end
  logic [CNT_W-1:0] hcount_q, vcount_q;
  logic             hsync_q, vsync_q, hblnk_q, vblnk_q, draw_q;
  logic [RGB_W-1:0] rgb_q;
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      draw_q   <= 1'b0;
      rgb_q    <= '0;
    end else begin
      hcount_q <= hcount_in;
      vcount_q <= vcount_in;
      hsync_q  <= hsync_in;
      vsync_q  <= vsync_in;
      hblnk_q  <= hblnk_in;
      vblnk_q  <= vblnk_in;
      draw_q   <= start_en & ~choice_en;
      rgb_q    <= rgb_in;
    end
  end
  logic [7:0]       idx;
  logic [NC-1:0]    occ_sh, own_sh, win_sh;
  logic             in_cell, on_edge, cur_hit;
  logic [RGB_W-1:0] rgb_d;
  assign idx     = 8'(row) * 8'(GRID_N) + 8'(col);
  assign occ_sh  = occ_q >> idx;
  assign own_sh  = own_q >> idx;
  assign win_sh  = win_q >> idx;
  assign in_cell = in_x & in_y & (xoff < XW'(CELL_W)) & (yoff < YW'(CELL_H));
  assign on_edge = (xoff < XW'(BORDER)) | (xoff >= XW'(CELL_W - BORDER)) |
                   (yoff < YW'(BORDER)) | (yoff >= YW'(CELL_H - BORDER));
  assign cur_hit = cur_en_q & (cur_idx_q == idx) & (cur_idx_q < 8'(NC)) & in_cell & on_edge;
  always_comb begin
    rgb_d = (hblnk_q | vblnk_q)             ? '0 :
            !draw_q                         ? rgb_q :
            cur_hit                         ? COLOR_CUR :
            (in_cell & win_sh[0] & phase_q) ? COLOR_WIN :
            (in_cell & occ_sh[0])           ? (own_sh[0] ? COLOR_P1 : COLOR_P0) :
                                              rgb_q;
  end
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_q;
      vcount_out <= vcount_q;
      hsync_out  <= hsync_q;
      vsync_out  <= vsync_q;
      hblnk_out  <= hblnk_q;
      vblnk_out  <= vblnk_q;
      rgb_out    <= rgb_d;
    end
  end
endmodule

// File: tb/tb_draw_board.sv
// tb_draw_board: directed scoreboard bench for draw_board using abbreviated lines and frames.
module tb_draw_board;
  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        start_en = 1'b0, choice_en = 1'b0, cursor_en = 1'b0;
  logic [8:0]  cell_occ = '0, cell_own = '0, win_mask = '0;
  logic [7:0]  cursor_idx = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  always #5 pclk = ~pclk;
  draw_board dut (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .start_en(start_en), .choice_en(choice_en), .cell_occ(cell_occ),
    .cell_own(cell_own), .win_mask(win_mask), .cursor_en(cursor_en), .cursor_idx(cursor_idx),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );
  typedef struct {
    logic [10:0] hc;
    logic [10:0] vc;
    logic [3:0]  st;
    logic [11:0] rgb;
    logic        chk;
  } exp_t;
  exp_t  sb[$];
  string tq[$];
  int    checks = 0, failures = 0;
  task automatic compare();
    exp_t  e;
    string t;
    e = sb.pop_front();
    t = tq.pop_front();
    checks++;
    assert (hcount_out === e.hc) else begin
      failures++;
      $error("FAIL %s hcount got=%0d exp=%0d", t, hcount_out, e.hc);
    end
    checks++;
    assert (vcount_out === e.vc) else begin
      failures++;
      $error("FAIL %s vcount got=%0d exp=%0d", t, vcount_out, e.vc);
    end
    checks++;
    assert ({hsync_out, vsync_out, hblnk_out, vblnk_out} === e.st) else begin
      failures++;
      $error("FAIL %s strobes got=%b exp=%b", t, {hsync_out, vsync_out, hblnk_out, vblnk_out}, e.st);
    end
    if (e.chk) begin
      checks++;
      assert (rgb_out === e.rgb) else begin
        failures++;
        $error("FAIL %s rgb got=%h exp=%h", t, rgb_out, e.rgb);
      end
    end
  endtask
  task automatic cyc(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb,
                     input logic [11:0] rgb, input logic chk, input logic [11:0] er, input string tag);
    hcount_in = h;
    vcount_in = v;
    hsync_in  = h[0];
    vsync_in  = v[0];
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = rgb;
    if (rst) sb.push_back(exp_t'{11'd0, 11'd0, 4'd0, 12'd0, 1'b1});
    else sb.push_back(exp_t'{h, v, {h[0], v[0], hb, vb}, er, chk});
    tq.push_back(tag == "" ? "timing" : tag);
    @(posedge pclk);
    #1;
    if (sb.size() >= 2) compare();
  endtask
  // walk lines ORIGIN_Y..y (one hcount=0 cycle each), then sweep columns from ORIGIN_X to x
  task automatic pix(input int x, input int y, input logic [11:0] rin, input logic [11:0] er,
                     input string tag, input logic hb);
    for (int v = 200; v <= y; v++) cyc(11'd0, 11'(v), 1'b0, 1'b0, rin, 1'b0, 12'd0, "");
    for (int h = 320; h < x; h++) cyc(11'(h), 11'(y), 1'b0, 1'b0, rin, 1'b0, 12'd0, "");
    cyc(11'(x), 11'(y), hb, 1'b0, rin, 1'b1, er, tag);
  endtask
  task automatic frame();
    cyc(11'd1, 11'd0, 1'b0, 1'b1, 12'h123, 1'b1, 12'h000, "vblank");
    cyc(11'd1, 11'd1, 1'b0, 1'b0, 12'h123, 1'b0, 12'h000, "");
  endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask
  initial begin
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      start_en   = 1'($urandom);
      cell_occ   = 9'($urandom);
      cell_own   = 9'($urandom);
      win_mask   = 9'($urandom);
      cursor_en  = 1'($urandom);
      cursor_idx = 8'($urandom);
      cyc(11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom), 12'($urandom), 1'b1, 12'd0, "reset");
    end
    rst = 1'b0;
    start_en = 1'b1; choice_en = 1'b0; cursor_en = 1'b0; cursor_idx = 8'd0;
    cell_occ = 9'h001; cell_own = 9'h000; win_mask = 9'h000;
    for (int i = 0; i < 4; i++) cyc(11'($urandom), 11'($urandom), 1'b0, 1'b0, 12'h0, 1'b0, 12'h0, "post_reset");
    frame();
    pix(320, 200, 12'h5A5, 12'hF00, "cell0_corner", 1'b0);
    pix(439, 200, 12'h5A5, 12'hF00, "cell0_right_edge", 1'b0);
    pix(440, 200, 12'h5A5, 12'h5A5, "gap_x", 1'b0);
    pix(447, 200, 12'h5A5, 12'h5A5, "gap_x_end", 1'b0);
    pix(448, 200, 12'h3C3, 12'h3C3, "cell1_empty", 1'b0);
    pix(320, 320, 12'h3C3, 12'h3C3, "gap_y", 1'b0);
    cell_occ = 9'h011; cell_own = 9'h010; cursor_en = 1'b1; cursor_idx = 8'd4;
    frame();
    pix(448, 328, 12'h0A0, 12'hFF0, "cursor_corner", 1'b0);
    pix(500, 380, 12'h0A0, 12'h00F, "cursor_interior", 1'b0);
    pix(451, 360, 12'h0A0, 12'hFF0, "cursor_left_border", 1'b0);
    pix(452, 360, 12'h0A0, 12'h00F, "cursor_inside_border", 1'b0);
    pix(567, 360, 12'h0A0, 12'hFF0, "cursor_right_border", 1'b0);
    pix(320, 200, 12'h0A0, 12'hF00, "cell0_with_cursor", 1'b0);
    cursor_idx = 8'd9;
    frame();
    pix(448, 328, 12'h0A0, 12'h00F, "cursor_out_of_range", 1'b0);
    pix(300 + 200, 300, 12'h777, 12'h777, "latch_line300", 1'b0);
    cell_occ = 9'h000;
    pix(500, 380, 12'h777, 12'h00F, "latch_same_frame", 1'b0);
    frame();
    pix(500, 380, 12'h777, 12'h777, "latch_next_frame", 1'b0);
    cursor_en = 1'b0; cell_occ = 9'h111; cell_own = 9'h010; win_mask = 9'h111;
    frame();
    pix(320, 200, 12'h111, 12'hF00, "blink_phase0", 1'b0);
    frames(29);
    pix(320, 200, 12'h111, 12'hF00, "blink_cnt29", 1'b0);
    frame();
    pix(320, 200, 12'h111, 12'hFFF, "blink_on_cell0", 1'b0);
    pix(500, 380, 12'h111, 12'hFFF, "blink_on_cell4", 1'b0);
    pix(600, 470, 12'h111, 12'hFFF, "blink_on_cell8", 1'b0);
    pix(448, 200, 12'h111, 12'h111, "blink_cell1_empty", 1'b0);
    win_mask = 9'h000;
    frame();
    pix(320, 200, 12'h111, 12'hF00, "win_cleared", 1'b0);
    win_mask = 9'h111;
    frame();
    pix(500, 380, 12'h111, 12'h00F, "phase_reset", 1'b0);
    frames(29);
    pix(500, 380, 12'h111, 12'h00F, "phase_reset_cnt29", 1'b0);
    frame();
    pix(500, 380, 12'h111, 12'hFFF, "phase_reset_toggle", 1'b0);
    choice_en = 1'b1;
    pix(320, 200, 12'h3C3, 12'h3C3, "choice_hidden", 1'b0);
    for (int i = 0; i < 8; i++) begin
      r = 12'($urandom);
      cyc(11'($urandom), 11'($urandom), 1'b0, 1'b0, r, 1'b1, r, "choice_passthru");
    end
    choice_en = 1'b0;
    pix(320, 200, 12'h3C3, 12'h000, "hblank_blackout", 1'b1);
    start_en = 1'b0;
    pix(320, 200, 12'h3C3, 12'h3C3, "stopped_hidden", 1'b0);
    cyc(11'd0, 11'd0, 1'b0, 1'b0, 12'h0, 1'b0, 12'h0, "");
    cyc(11'd0, 11'd0, 1'b0, 1'b0, 12'h0, 1'b0, 12'h0, "");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
